// File: rtl/game_pkg.sv
// Shared types and constants for the per-frame dog physics scheduler.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UPD_REQ,
        UPD_WAIT,
        COL_REQ,
        COL_WAIT,
        DONE
    } sched_state_t;

    localparam int CD_W      = 4;
    localparam int N_DEFAULT = 4;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    localparam int NUM_PAIRS = num_pairs(N_DEFAULT);

    // Flat index of unordered pair (a,b), a<b, in lexicographic order.
    function automatic int pair_idx(input int a, input int b, input int n);
        return a * (2 * n - a - 1) / 2 + (b - a - 1);
    endfunction

    function automatic int idx_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/game_phys_sched_if.sv
// Frame/update/collision/response signal bundle between scheduler (master) and datapath side (slave).
interface game_phys_sched_if
    import game_pkg::*;
#(
    parameter int IDX_W = 3
);
    // Handshakes: a transfer happens in a cycle where valid && ready; valid holds, with its payload stable, until then.
    logic             frame_tick;
    logic             enable;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_ready;
    logic             upd_done;
    logic             col_valid;
    logic [IDX_W-1:0] col_a;
    logic [IDX_W-1:0] col_b;
    logic             col_ready;
    logic             col_done;
    logic             col_overlap;
    logic             resp_valid;
    logic [IDX_W-1:0] resp_a;
    logic [IDX_W-1:0] resp_b;
    logic             busy;
    logic             frame_done;
    logic [7:0]       overrun_cnt;
    logic             wd_err;
    sched_state_t     dbg_state;

    modport master (
        input  frame_tick, enable, upd_ready, upd_done, col_ready, col_done, col_overlap,
        output upd_valid, upd_idx, col_valid, col_a, col_b, resp_valid, resp_a, resp_b,
               busy, frame_done, overrun_cnt, wd_err, dbg_state
    );

    modport slave (
        output frame_tick, enable, upd_ready, upd_done, col_ready, col_done, col_overlap,
        input  upd_valid, upd_idx, col_valid, col_a, col_b, resp_valid, resp_a, resp_b,
               busy, frame_done, overrun_cnt, wd_err, dbg_state
    );

endinterface

// File: rtl/game_pair_cooldown.sv
// Per-pair cooldown counters: load on grant, global saturating-at-zero decrement, zero flag per pair.
module game_pair_cooldown
    import game_pkg::*;
#(
    parameter int NUM_P  = 6,
    parameter int PIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_dec,
    input  logic              i_load,
    input  logic [PIDX_W-1:0] i_load_idx,
    input  logic [CD_W-1:0]   i_load_val,
    output logic [NUM_P-1:0]  o_zero
);

    logic [CD_W-1:0] r_cd [NUM_P];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_P; p++) r_cd[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_P; p++) begin
                if (i_load && (i_load_idx == PIDX_W'(p))) begin
                    r_cd[p] <= i_load_val;
                end else if (i_dec && (r_cd[p] != '0)) begin
                    r_cd[p] <= r_cd[p] - 1'b1;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_P; p++) begin : g_zero
        assign o_zero[p] = (r_cd[p] == '0);
    end

endmodule

// File: rtl/game_phys_sched.sv
// Frame scheduler: updates each dog, then checks every pair and grants bounces subject to cooldown.
// Optional watchdog on the WAIT states: define GAME_SCHED_WATCHDOG_EN.
module game_phys_sched
    import game_pkg::*;
#(
    parameter int N         = 4,
    parameter int IDX_W     = 3,
    parameter int CD_FRAMES = 5,
    parameter int WD_CYCLES = 63
) (
    input  logic                clk,
    input  logic                rst_n,
    game_phys_sched_if.master   bus
);

    localparam int NUM_P  = num_pairs(N);
    localparam int PIDX_W = idx_w(NUM_P);
    localparam int DW     = idx_w(N);

    sched_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_dog, r_a, r_b, r_resp_a, r_resp_b;
    logic               r_resp_valid;
    logic [7:0]         r_overrun;
    logic               w_accept, w_grant, w_last_pair, w_wd_trip;
    logic [NUM_P-1:0]   w_zero;
    logic [PIDX_W-1:0]  w_pair;
    logic [PIDX_W-1:0]  w_pair_lut [N][N];

    for (genvar a = 0; a < N; a++) begin : g_lut_a
        for (genvar b = 0; b < N; b++) begin : g_lut_b
            assign w_pair_lut[a][b] = (b > a) ? PIDX_W'(pair_idx(a, b, N)) : '0;
        end
    end

    assign w_pair      = w_pair_lut[r_a[DW-1:0]][r_b[DW-1:0]];
    assign w_last_pair = (r_a == IDX_W'(N - 2)) && (r_b == IDX_W'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.frame_tick && bus.enable) begin
                    w_accept    = 1'b1;
                    w_state_nxt = UPD_REQ;
                end
            end
            UPD_REQ:  if (bus.upd_ready) w_state_nxt = UPD_WAIT;
            UPD_WAIT: begin
                if (bus.upd_done) begin
                    w_state_nxt = (r_dog == IDX_W'(N - 1)) ? COL_REQ : UPD_REQ;
                end else if (w_wd_trip) begin
                    w_state_nxt = DONE;
                end
            end
            COL_REQ:  if (bus.col_ready) w_state_nxt = COL_WAIT;
            COL_WAIT: begin
                if (bus.col_done) begin
                    w_grant     = bus.col_overlap && w_zero[w_pair];
                    w_state_nxt = w_last_pair ? DONE : COL_REQ;
                end else if (w_wd_trip) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dog        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_resp_valid <= 1'b0;
            r_resp_a     <= '0;
            r_resp_b     <= '0;
            r_overrun    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_grant;
            if (w_grant) begin
                r_resp_a <= r_a;
                r_resp_b <= r_b;
            end
            if (bus.frame_tick && (r_state != IDLE) && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end
            if (w_accept) begin
                r_dog <= '0;
            end else if ((r_state == UPD_WAIT) && bus.upd_done) begin
                if (r_dog == IDX_W'(N - 1)) begin
                    r_a <= '0;
                    r_b <= IDX_W'(1);
                end else begin
                    r_dog <= r_dog + 1'b1;
                end
            end
            if ((r_state == COL_WAIT) && bus.col_done && !w_last_pair) begin
                if (r_b == IDX_W'(N - 1)) begin
                    r_a <= r_a + 1'b1;
                    r_b <= r_a + IDX_W'(2);
                end else begin
                    r_b <= r_b + 1'b1;
                end
            end
        end
    end

`ifdef GAME_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;

    // Restarts from zero on every state change, so each WAIT gets a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wd_cnt <= '0;
        end else if (((r_state == UPD_WAIT) || (r_state == COL_WAIT)) &&
                     (r_wd_cnt != WD_W'(WD_CYCLES))) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_trip = (((r_state == UPD_WAIT) && !bus.upd_done) ||
                        ((r_state == COL_WAIT) && !bus.col_done)) &&
                       (r_wd_cnt == WD_W'(WD_CYCLES));
`else
    assign w_wd_trip = 1'b0;
`endif

    game_pair_cooldown #(
        .NUM_P  (NUM_P),
        .PIDX_W (PIDX_W)
    ) u_cooldown (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_dec      (w_accept),
        .i_load     (w_grant),
        .i_load_idx (w_pair),
        .i_load_val (CD_W'(CD_FRAMES)),
        .o_zero     (w_zero)
    );

    assign bus.upd_valid   = (r_state == UPD_REQ);
    assign bus.upd_idx     = r_dog;
    assign bus.col_valid   = (r_state == COL_REQ);
    assign bus.col_a       = r_a;
    assign bus.col_b       = r_b;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_a      = r_resp_a;
    assign bus.resp_b      = r_resp_b;
    assign bus.busy        = (r_state != IDLE);
    assign bus.frame_done  = (r_state == DONE);
    assign bus.overrun_cnt = r_overrun;
    assign bus.wd_err      = w_wd_trip;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_game_phys_sched.sv
// Self-checking bench for game_phys_sched with N=4: event scoreboard plus frame vector table.
module tb_game_phys_sched;
    import game_pkg::*;

    localparam int N     = 4;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    game_phys_sched_if #(.IDX_W(IDX_W)) bus ();

    game_phys_sched #(
        .N(N), .IDX_W(IDX_W), .CD_FRAMES(5), .WD_CYCLES(63)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0] ovl;
        logic [5:0] resp;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          wd_seen = 0;
    logic [11:0] exp_q[$];
    logic [5:0]  cur_overlap = '0;
    logic        hold_done = 1'b0;
    int          upd_cd = 0;
    int          col_cd = 0;
    int          col_pidx = 0;
    vec_t        vecs[10];

    function automatic logic [11:0] ev(input int kind, input int a, input int b);
        return {4'(kind), 4'(a), 4'(b)};
    endfunction

    function automatic int tb_pidx(input int a, input int b);
        int k = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                if (i == a && j == b) return k;
                k++;
            end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic sb(input logic [11:0] act, input string name);
        logic [11:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %03h, expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL %s: got event %03h expected %03h", name, act, e);
            end
        end
    endtask

    // Datapath model: done pulses two cycles after each accepted request.
    initial begin
        bus.upd_done = 1'b0;
        bus.col_done = 1'b0;
        bus.col_overlap = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.upd_done = 1'b0;
            bus.col_done = 1'b0;
            bus.col_overlap = 1'b0;
            if (!rst_n) begin
                upd_cd = 0;
                col_cd = 0;
            end else if (!hold_done) begin
                if (upd_cd > 0) begin
                    upd_cd--;
                    if (upd_cd == 0) bus.upd_done = 1'b1;
                end
                if (col_cd > 0) begin
                    col_cd--;
                    if (col_cd == 0) begin
                        bus.col_done = 1'b1;
                        bus.col_overlap = cur_overlap[col_pidx];
                    end
                end
            end
            @(negedge clk);
            if (rst_n && bus.upd_valid && bus.upd_ready) upd_cd = 2;
            if (rst_n && bus.col_valid && bus.col_ready) begin
                col_cd = 2;
                col_pidx = tb_pidx(int'(bus.col_a), int'(bus.col_b));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.resp_valid) sb(ev(3, int'(bus.resp_a), int'(bus.resp_b)), "resp");
                if (bus.upd_valid && bus.upd_ready) sb(ev(1, int'(bus.upd_idx), 0), "upd");
                if (bus.col_valid && bus.col_ready) sb(ev(2, int'(bus.col_a), int'(bus.col_b)), "col");
                if (bus.frame_done) sb(ev(4, 0, 0), "frame_done");
                if (bus.wd_err) wd_seen++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic push_frame(input logic [5:0] resp);
        int p = 0;
        for (int d = 0; d < N; d++) exp_q.push_back(ev(1, d, 0));
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++) begin
                exp_q.push_back(ev(2, a, b));
                if (resp[p]) exp_q.push_back(ev(3, a, b));
                p++;
            end
        exp_q.push_back(ev(4, 0, 0));
    endtask

    task automatic pulse_tick();
        @(posedge clk);
        #1 bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || bus.busy) && n < max_cycles);
        checks++;
        if (exp_q.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL %s: timeout, %0d events pending busy=%0b, expected 0 pending and idle",
                     name, exp_q.size(), bus.busy);
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input logic [5:0] ovl, input logic [5:0] resp, input string name);
        cur_overlap = ovl;
        push_frame(resp);
        pulse_tick();
        @(negedge clk);
        check({name, "_latency_busy"}, 32'(bus.busy), 32'd1);
        check({name, "_latency_upd_valid"}, 32'(bus.upd_valid), 32'd1);
        wait_idle(400, name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_upd_valid"}, 32'(bus.upd_valid), 32'd0);
        check({name, "_upd_idx"}, 32'(bus.upd_idx), 32'd0);
        check({name, "_col_valid"}, 32'(bus.col_valid), 32'd0);
        check({name, "_col_ab"}, {bus.col_a, bus.col_b}, 32'd0);
        check({name, "_resp"}, {bus.resp_valid, bus.resp_a, bus.resp_b}, 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({name, "_overrun"}, 32'(bus.overrun_cnt), 32'd0);
        check({name, "_wd_err"}, 32'(bus.wd_err), 32'd0);
    endtask

    initial begin
        // Cooldown 5, decremented at each accepted frame before the checks of that frame.
        vecs[0] = '{6'h00, 6'h00};
        vecs[1] = '{6'h10, 6'h10};
        vecs[2] = '{6'h10, 6'h00};
        vecs[3] = '{6'h10, 6'h00};
        vecs[4] = '{6'h10, 6'h00};
        vecs[5] = '{6'h10, 6'h00};
        vecs[6] = '{6'h10, 6'h10};
        vecs[7] = '{6'h10, 6'h00};
        vecs[8] = '{6'h3F, 6'h2F};
        vecs[9] = '{6'h3F, 6'h00};

        bus.frame_tick = 1'b0;
        bus.enable = 1'b1;
        bus.upd_ready = 1'b1;
        bus.col_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].ovl, vecs[i].resp, $sformatf("vec%0d", i));
        end

        // Update request stalled by ready.
        @(posedge clk);
        #1 bus.upd_ready = 1'b0;
        cur_overlap = '0;
        push_frame(6'h00);
        pulse_tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_upd_valid", 32'(bus.upd_valid), 32'd1);
            check("stall_upd_idx", 32'(bus.upd_idx), 32'd0);
        end
        @(posedge clk);
        #1 bus.upd_ready = 1'b1;
        wait_idle(400, "stall_frame");

        // Disabled tick is neither a frame nor an overrun.
        bus.enable = 1'b0;
        pulse_tick();
        repeat (3) @(negedge clk);
        check("disabled_busy", 32'(bus.busy), 32'd0);
        check("disabled_overrun", 32'(bus.overrun_cnt), 32'd0);
        bus.enable = 1'b1;

        cur_overlap = '0;
        push_frame(6'h00);
        pulse_tick();
        repeat (3) pulse_tick();
        wait_idle(400, "overrun_frame");
        check("overrun_3", 32'(bus.overrun_cnt), 32'd3);

        // Collision request held off while ticks pile up.
        @(posedge clk);
        #1 bus.col_ready = 1'b0;
        push_frame(6'h00);
        pulse_tick();
        begin
            int n = 0;
            while (!bus.col_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("col_stall_reached", 32'(bus.col_valid), 32'd1);
        end
        repeat (300) pulse_tick();
        @(negedge clk);
        check("overrun_sat", 32'(bus.overrun_cnt), 32'd255);
        check("overrun_sat_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 bus.col_ready = 1'b1;
        wait_idle(400, "sat_frame");
        check("overrun_sat_after", 32'(bus.overrun_cnt), 32'd255);

        // Reset while waiting on pair (0,2), after pair (0,1) was granted.
        cur_overlap = 6'h3F;
        push_frame(6'h3F);
        pulse_tick();
        begin
            int n = 0;
            logic seen = 1'b0;
            while (!seen && n < 200) begin
                @(negedge clk);
                n++;
                seen = bus.col_valid && bus.col_ready && bus.col_a == 0 && bus.col_b == 2;
            end
            check("reset_point_reached", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_frame(6'h3F, 6'h3F, "post_reset");

`ifdef GAME_SCHED_WATCHDOG_EN
        begin
            int n = 0;
            hold_done = 1'b1;
            exp_q.push_back(ev(1, 0, 0));
            exp_q.push_back(ev(4, 0, 0));
            pulse_tick();
            @(negedge clk);
            check("wd_upd_xfer", 32'(bus.upd_valid && bus.upd_ready), 32'd1);
            do begin
                @(negedge clk);
                n++;
            end while (!bus.wd_err && n < 200);
            check("wd_delay", 32'(n), 32'd64);
            @(negedge clk);
            check("wd_frame_done", 32'(bus.frame_done), 32'd1);
            @(negedge clk);
            check("wd_idle", 32'(bus.busy), 32'd0);
            hold_done = 1'b0;
            wait_idle(50, "wd_frame");
        end
`else
        check("wd_err_never", 32'(wd_seen), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
